// File: rtl/usr_seq_if.sv
// Command/data bundle for the usr_seq shift sequencer.
// The master drives commands and serial fill bits; the slave returns register state and status.
interface usr_seq_if #(
  parameter int N  = 8,
  parameter int AW = $clog2(N + 1)
);
  logic          start;
  logic [2:0]    op;
  logic [AW-1:0] amt;
  logic [N-1:0]  d;
  logic          sin_l;
  logic          sin_r;
  logic [N-1:0]  q;
  logic          busy;
  logic          done;
  logic          sout;

  modport master (
    output start, op, amt, d, sin_l, sin_r,
    input  q, busy, done, sout
  );

  modport slave (
    input  start, op, amt, d, sin_l, sin_r,
    output q, busy, done, sout
  );
endinterface

// File: rtl/usr_seq.sv
// Universal shift register sequencer: single-cycle nop/load/clear and
// multi-cycle shifts/rotates that move one position per clock.
module usr_seq #(
  parameter int N  = 8,
  parameter int AW = $clog2(N + 1)
) (
  input  logic   clock,
  input  logic   reset,
  usr_seq_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SLL  = 3'b010;
  localparam logic [2:0] OP_SRL  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  localparam logic [AW-1:0] N_AMT   = AW'(N);
  localparam logic [AW-1:0] ONE_AMT = AW'(1);

  state_t        state_q, state_d;
  logic [N-1:0]  q_q, q_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          done_q, done_d;
  logic          sout_q, sout_d;

  function automatic logic [N-1:0] step_q(input logic [2:0] op, input logic [N-1:0] v,
                                          input logic sl, input logic sr);
    case (op)
      OP_SLL:  step_q = {v[N-2:0], sr};
      OP_SRL:  step_q = {sl, v[N-1:1]};
      OP_ROL:  step_q = {v[N-2:0], v[N-1]};
      OP_ROR:  step_q = {v[0], v[N-1:1]};
      OP_ASR:  step_q = {v[N-1], v[N-1:1]};
      default: step_q = v;
    endcase
  endfunction

  // Left-moving ops eject the MSB, all right-moving ops eject the LSB.
  function automatic logic step_out(input logic [2:0] op, input logic [N-1:0] v);
    case (op)
      OP_SLL:  step_out = v[N-1];
      OP_ROL:  step_out = v[N-1];
      default: step_out = v[0];
    endcase
  endfunction

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      q_q     <= {N{1'b0}};
      cnt_q   <= {AW{1'b0}};
      op_q    <= 3'b000;
      done_q  <= 1'b0;
      sout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      done_q  <= done_d;
      sout_q  <= sout_d;
    end
  end

  // Command acceptance, shift stepping and completion.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    done_d  = 1'b0;
    sout_d  = sout_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_NOP:  done_d = 1'b1;
            OP_LOAD: begin
              q_d    = bus.d;
              done_d = 1'b1;
            end
            OP_CLR: begin
              q_d    = {N{1'b0}};
              done_d = 1'b1;
            end
            default: begin
              if (bus.amt == {AW{1'b0}}) begin
                done_d = 1'b1;
              end else begin
                cnt_d   = (bus.amt > N_AMT) ? N_AMT : bus.amt;
                op_d    = bus.op;
                state_d = SHIFT;
              end
            end
          endcase
        end else begin
          done_d = 1'b0;
        end
      end
      SHIFT: begin
        q_d    = step_q(op_q, q_q, bus.sin_l, bus.sin_r);
        sout_d = step_out(op_q, q_q);
        cnt_d  = cnt_q - ONE_AMT;
        if (cnt_q == ONE_AMT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = done_q;
  assign bus.sout = sout_q;

endmodule

// File: tb/tb_usr_seq.sv
// Directed bench for usr_seq (N=8): a closed-form command model checked every
// cycle, plus literal expectations for the reference scenarios.
module tb_usr_seq;

  localparam int N  = 8;
  localparam int AW = $clog2(N + 1);

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  usr_seq_if #(.N(N), .AW(AW)) bus ();

  usr_seq #(.N(N), .AW(AW)) u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Final value of a k-position shift, from whole-word arithmetic.
  function automatic logic [7:0] shift_result(input logic [2:0] op, input logic [7:0] v,
                                              input int k, input logic sl, input logic sr);
    int vi;
    int hi_fill;
    int lo_fill;
    int r;
    vi      = int'(v);
    lo_fill = (1 << k) - 1;
    hi_fill = (255 << (8 - k)) & 255;
    case (op)
      3'b010:  r = (vi << k) | (sr ? lo_fill : 0);
      3'b011:  r = (vi >> k) | (sl ? hi_fill : 0);
      3'b100:  r = (vi << k) | (vi >> (8 - k));
      3'b101:  r = (vi >> k) | (vi << (8 - k));
      3'b110:  r = (vi >> k) | (v[7] ? hi_fill : 0);
      default: r = vi;
    endcase
    shift_result = 8'(r & 255);
  endfunction

  // Last bit to leave the word after k positions.
  function automatic logic shift_out(input logic [2:0] op, input logic [7:0] v, input int k);
    int vi;
    vi = int'(v);
    if (op == 3'b010 || op == 3'b100) shift_out = 1'(((vi >> (8 - k)) & 1));
    else                              shift_out = 1'(((vi >> (k - 1)) & 1));
  endfunction

  logic [7:0] m_q, m_fq;
  logic       m_sout, m_fs, m_done;
  int         m_busy_cnt;

  // Reference model: tracks remaining busy cycles and the committed result.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q        <= 8'h00;
      m_sout     <= 1'b0;
      m_done     <= 1'b0;
      m_busy_cnt <= 0;
      m_fq       <= 8'h00;
      m_fs       <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy_cnt != 0) begin
        m_busy_cnt <= m_busy_cnt - 1;
        if (m_busy_cnt == 1) begin
          m_q    <= m_fq;
          m_sout <= m_fs;
          m_done <= 1'b1;
        end
      end else if (bus.start) begin
        case (bus.op)
          3'b000: m_done <= 1'b1;
          3'b001: begin m_q <= bus.d; m_done <= 1'b1; end
          3'b111: begin m_q <= 8'h00; m_done <= 1'b1; end
          default: begin
            if (bus.amt == 0) begin
              m_done <= 1'b1;
            end else begin
              m_busy_cnt <= (int'(bus.amt) > 8) ? 8 : int'(bus.amt);
              m_fq <= shift_result(bus.op, m_q, (int'(bus.amt) > 8) ? 8 : int'(bus.amt),
                                   bus.sin_l, bus.sin_r);
              m_fs <= shift_out(bus.op, m_q, (int'(bus.amt) > 8) ? 8 : int'(bus.amt));
            end
          end
        endcase
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clock) begin
    check("busy", 32'(bus.busy), 32'(m_busy_cnt != 0));
    check("done", 32'(bus.done), 32'(m_done));
    if (m_busy_cnt == 0) begin
      check("q", 32'(bus.q), 32'(m_q));
      check("sout", 32'(bus.sout), 32'(m_sout));
    end
  end

  // Present one command at the next edge; returns at E0+1.
  task automatic issue(input logic [2:0] op, input logic [AW-1:0] amt, input logic [7:0] d);
    bus.start = 1'b1;
    bus.op    = op;
    bus.amt   = amt;
    bus.d     = d;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  // Wait for the done pulse, counting busy cycles; bounded.
  task automatic wait_done(output int busy_cycles);
    bit seen;
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_cycles++;
      @(posedge clock); #1;
    end
    check("done_timeout", 32'(seen), 32'd1);
  endtask

  int bc;

  initial begin
    checks = 0;
    errors = 0;
    bus.start = 1'b0;
    bus.op    = 3'b000;
    bus.amt   = '0;
    bus.d     = 8'h00;
    bus.sin_l = 1'b0;
    bus.sin_r = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_q", 32'(bus.q), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_sout", 32'(bus.sout), 32'h0);
    #17 reset = 1'b1;
    @(posedge clock); #1;

    issue(3'b001, 4'd0, 8'hA5);
    check("load_q", 32'(bus.q), 32'hA5);
    check("load_done", 32'(bus.done), 32'h1);
    check("load_busy", 32'(bus.busy), 32'h0);

    bus.sin_r = 1'b1;
    issue(3'b010, 4'd3, 8'h00);
    wait_done(bc);
    check("sll_busy_cycles", 32'(bc), 32'd3);
    check("sll_q", 32'(bus.q), 32'h2F);
    check("sll_sout", 32'(bus.sout), 32'h1);
    bus.sin_r = 1'b0;
    @(posedge clock); #1;
    check("sll_done_once", 32'(bus.done), 32'h0);

    issue(3'b001, 4'd0, 8'h90);
    issue(3'b110, 4'd2, 8'h00);
    wait_done(bc);
    check("asr_q", 32'(bus.q), 32'hE4);
    check("asr_sout", 32'(bus.sout), 32'h0);

    issue(3'b001, 4'd0, 8'h3C);
    issue(3'b101, 4'd12, 8'h00);
    wait_done(bc);
    check("ror_busy_cycles", 32'(bc), 32'd8);
    check("ror_q", 32'(bus.q), 32'h3C);

    issue(3'b001, 4'd0, 8'h18);
    issue(3'b010, 4'd4, 8'h00);
    bus.start = 1'b1;
    bus.op    = 3'b111;
    @(posedge clock); #1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    wait_done(bc);
    check("ignore_clr_q", 32'(bus.q), 32'h80);
    check("ignore_clr_sout", 32'(bus.sout), 32'h1);

    issue(3'b011, 4'd0, 8'h00);
    check("srl0_q", 32'(bus.q), 32'h80);
    check("srl0_done", 32'(bus.done), 32'h1);
    check("srl0_busy", 32'(bus.busy), 32'h0);
    @(posedge clock); #1;

    bus.sin_l = 1'b1;
    issue(3'b011, 4'd3, 8'h00);
    wait_done(bc);
    check("srl_q", 32'(bus.q), 32'hF0);
    bus.sin_l = 1'b0;
    issue(3'b100, 4'd1, 8'h00);
    wait_done(bc);
    check("rol_q", 32'(bus.q), 32'hE1);
    check("rol_sout", 32'(bus.sout), 32'h1);
    issue(3'b001, 4'd0, 8'h5A);
    check("b2b_load_q", 32'(bus.q), 32'h5A);
    issue(3'b111, 4'd0, 8'h00);
    check("clr_q", 32'(bus.q), 32'h00);
    check("clr_sout_kept", 32'(bus.sout), 32'h1);
    issue(3'b000, 4'd0, 8'hFF);
    check("nop_done", 32'(bus.done), 32'h1);
    @(posedge clock); #1;

    issue(3'b001, 4'd0, 8'hFF);
    issue(3'b010, 4'd5, 8'h00);
    @(posedge clock); #1;
    #2 reset = 1'b0;
    #1;
    check("abort_q", 32'(bus.q), 32'h0);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_done", 32'(bus.done), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock); #1;
      check("abort_no_done", 32'(bus.done), 32'h0);
    end

    issue(3'b001, 4'd0, 8'h33);
    check("post_rst_load", 32'(bus.q), 32'h33);
    @(posedge clock); #1;
    @(posedge clock); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
